adder_n: RTL and testbench



---
 rtl/adder_n_if.sv | 14 +
 rtl/adder_n.sv | 34 +++
 tb/tb_adder_n.sv | 117 +++++++++++
 3 files changed

// File: rtl/adder_n_if.sv
// Operand/result bundle for adder_n: operands and carry-in flow master->slave,
// registered sum and carry-out flow back.
interface adder_n_if #(
  parameter int unsigned bits = 4
);
  logic            carryin;
  logic [bits-1:0] A;
  logic [bits-1:0] B;
  logic [bits-1:0] Sum;
  logic            carryout;

  modport master (output carryin, output A, output B, input Sum, input carryout);
  modport slave  (input carryin, input A, input B, output Sum, output carryout);
endinterface

// File: rtl/adder_n.sv
// N-bit ripple-carry adder built from full-adder cells, with the sum and carry-out
// captured in an output register every clock.
module adder_n #(
  parameter int unsigned bits = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  adder_n_if.slave  bus
);

  logic [bits:0]   carry;
  logic [bits-1:0] sum_c;

  assign carry[0] = bus.carryin;

  // One full-adder cell per bit; the carry ripples from bit 0 up to the MSB.
  for (genvar i = 0; i < int'(bits); i++) begin : g_fa
    assign sum_c[i]   = bus.A[i] ^ bus.B[i] ^ carry[i];
    assign carry[i+1] = (bus.A[i] & bus.B[i]) |
                        (bus.A[i] & carry[i]) |
                        (bus.B[i] & carry[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Sum      <= '0;
      bus.carryout <= 1'b0;
    end else begin
      bus.Sum      <= sum_c;
      bus.carryout <= carry[bits];
    end
  end

endmodule

// File: tb/tb_adder_n.sv
// Directed and exhaustive bench for adder_n at bits = 4, using a scoreboard queue
// of expected {carryout, Sum} values.
module tb_adder_n;

  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [W:0] sb[$];

  adder_n_if #(.bits(W)) bus ();

  adder_n #(.bits(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W:0] exp);
    logic [W:0] obs;
    obs = {bus.carryout, bus.Sum};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (A=%0d B=%0d ci=%0d)",
             tag, obs, exp, bus.A, bus.B, bus.carryin);
    end
  endtask

  // Drive operands after a falling edge, then check one cycle later at posedge+1.
  task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci);
    logic [W:0] exp;
    bus.A       = a;
    bus.B       = b;
    bus.carryin = ci;
    sb.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(ci));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: scoreboard empty, observed %0d expected an entry",
             tag, {bus.carryout, bus.Sum});
    end else begin
      exp = sb.pop_front();
      check(tag, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] idx;
    n_cmp = 0;
    n_bad = 0;

    // Reset held with nonzero operands: outputs stay zero across edges.
    rst_n       = 1'b0;
    bus.A       = 4'd9;
    bus.B       = 4'd5;
    bus.carryin = 1'b1;
    #1;
    check("reset_initial", '0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset_hold", '0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    step("basic_3_4",      4'd3,  4'd4,  1'b0);
    step("wrap_15_1",      4'd15, 4'd1,  1'b0);
    step("wrap_7_8_ci",    4'd7,  4'd8,  1'b1);
    step("max_15_15_ci",   4'd15, 4'd15, 1'b1);
    step("zero",           4'd0,  4'd0,  1'b0);
    step("ci_only",        4'd0,  4'd0,  1'b1);

    // Exhaustive sweep: A increments every cycle, B every 16 cycles.
    for (int ci = 0; ci < 2; ci++) begin
      for (int n = 0; n < 256; n++) begin
        idx = 8'(n);
        if (ci == 0 && n == 100) begin
          // Mid-stream reset pulsed between edges clears outputs immediately.
          bus.A       = 4'd15;
          bus.B       = 4'd15;
          bus.carryin = 1'b1;
          #2;
          rst_n = 1'b0;
          #1;
          check("midreset_async", '0);
          @(posedge clk);
          #1;
          check("midreset_hold", '0);
          @(negedge clk);
          rst_n = 1'b1;
        end
        step("sweep", idx[3:0], idx[7:4], 1'(ci));
      end
    end

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
